// File: rtl/powlib_busresp.sv
// powlib_busresp: windowed bus responder. Writes land in a small memory, reads
// return a word to a caller-supplied address, and other offsets are counted as errors.
`default_nettype none

module powlib_busresp #(
    parameter int              B_AW   = 16,
    parameter int              B_DW   = 32,
    parameter logic [B_AW-1:0] B_BASE = 16'h2000,
    parameter int              MAW    = 6,
    parameter                  ID     = "BUSRESP"
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [B_DW-1:0] rddata,
    input  logic [B_AW-1:0] rdaddr,
    input  logic            rdvld,
    output logic            rdrdy,
    output logic [B_DW-1:0] wrdata,
    output logic [B_AW-1:0] wraddr,
    output logic            wrvld,
    input  logic            wrrdy,
    output logic [7:0]      errcnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    if (B_DW < B_AW) begin : g_bad_width
        $error("%s: B_DW must be at least B_AW", ID);
    end

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [B_AW-1:0] offset;
    logic [B_AW-1:0] offset_hi;
    logic            accept;
    logic            is_wr;
    logic            is_rd;
    logic            is_drop;
    logic [MAW-1:0]  rd_idx;
    logic [B_AW-1:0] ret_addr;
    logic [B_DW-1:0] mem [2**MAW];

    // Unsigned wrap-around: addresses below the base land far above the window.
    assign offset    = rdaddr - B_BASE;
    assign offset_hi = offset >> MAW;
    assign is_wr     = (offset_hi == '0);
    assign is_rd     = (offset_hi == B_AW'(1));
    assign is_drop   = !is_wr && !is_rd;
    assign accept    = rdvld && rdrdy;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && is_rd) state_nxt = RD;
            RD:      state_nxt = RESP;
            RESP:    if (wrrdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rdrdy = rst && (state == IDLE);
    end

    // Memory and read context carry no reset; contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (accept && is_wr) begin
            mem[offset[MAW-1:0]] <= rddata;
        end
        if (accept && is_rd) begin
            rd_idx   <= offset[MAW-1:0];
            ret_addr <= rddata[B_AW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wrvld  <= 1'b0;
            wrdata <= '0;
            wraddr <= '0;
            errcnt <= 8'd0;
        end else begin
            if (state == RD) begin
                wrdata <= mem[rd_idx];
                wraddr <= ret_addr;
                wrvld  <= 1'b1;
            end else if (state == RESP && wrrdy) begin
                wrvld  <= 1'b0;
            end
            if (accept && is_drop && errcnt != 8'hFF) begin
                errcnt <= errcnt + 8'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_powlib_busresp.sv
// Randomized scoreboard bench for powlib_busresp against a word-array reference model.
`default_nettype none

module tb_powlib_busresp;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rddata;
    logic [15:0] rdaddr;
    logic        rdvld;
    logic        rdrdy;
    logic [31:0] wrdata;
    logic [15:0] wraddr;
    logic        wrvld;
    logic        wrrdy;
    logic [7:0]  errcnt;

    logic        rdy_manual;
    logic        man_rdy;
    logic        rnd_rdy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_m [64];
    int          exp_err;
    logic [47:0] exp_q [$];

    powlib_busresp #(
        .B_AW  (16),
        .B_DW  (32),
        .B_BASE(16'h2000),
        .MAW   (6),
        .ID    ("BUSRESP")
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rddata(rddata),
        .rdaddr(rdaddr),
        .rdvld (rdvld),
        .rdrdy (rdrdy),
        .wrdata(wrdata),
        .wraddr(wraddr),
        .wrvld (wrvld),
        .wrrdy (wrrdy),
        .errcnt(errcnt)
    );

    always #5 clk = ~clk;

    always_comb wrrdy = rdy_manual ? man_rdy : rnd_rdy;

    always @(posedge clk) begin
        #1;
        rnd_rdy = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: a response transfers at the next edge whenever vld and rdy are both high.
    always @(negedge clk) begin
        chk("rdrdy_wrvld_exclusive", {63'd0, rdrdy && wrvld}, 64'd0);
        if (rst === 1'b1 && wrvld && wrrdy) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_response", {16'd0, wraddr, wrdata}, 64'd0);
            end else begin
                logic [47:0] e;
                e = exp_q.pop_front();
                chk("response", {16'd0, wraddr, wrdata}, {16'd0, e});
            end
        end
    end

    // Drives one request, holds it until accepted, then applies the reference rules.
    task automatic do_req(input logic [15:0] a, input logic [31:0] d, output int waited);
        logic [15:0] off;
        rdaddr = a;
        rddata = d;
        rdvld  = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            if (rdrdy) break;
            waited++;
            if (waited > 50) begin
                chk("request_accept_timeout", 64'd0, 64'd1);
                rdvld = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        off = a - 16'h2000;
        if (off < 16'd64) begin
            mem_m[off] = d;
        end else if (off < 16'd128) begin
            exp_q.push_back({d[15:0], mem_m[off - 16'd64]});
        end else if (exp_err < 255) begin
            exp_err++;
        end
        #1;
    endtask

    task automatic idle_cycle();
        rdvld = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int w;
        logic [31:0] d0;
        logic [15:0] a0;
        logic [31:0] mid_val;

        rst        = 1'b0;
        rdvld      = 1'b0;
        rdaddr     = '0;
        rddata     = '0;
        rdy_manual = 1'b1;
        man_rdy    = 1'b0;
        rnd_rdy    = 1'b1;
        exp_err    = 0;

        // Reset held for two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_wrvld", {63'd0, wrvld}, 64'd0);
        chk("reset_rdrdy", {63'd0, rdrdy}, 64'd0);
        chk("reset_errcnt", {56'd0, errcnt}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rdrdy_after_reset", {63'd0, rdrdy}, 64'd1);
        @(posedge clk);
        #1;

        // Write then read of the same word in the very next cycle, with backpressure
        do_req(16'h2005, 32'hDEADBEEF, w);
        do_req(16'h2045, 32'h00001234, w);
        rdvld = 1'b0;
        @(negedge clk);
        chk("wrvld_not_yet", {63'd0, wrvld}, 64'd0);
        @(negedge clk);
        chk("wrvld_latency", {63'd0, wrvld}, 64'd1);
        chk("wraddr_first", {48'd0, wraddr}, 64'h1234);
        chk("wrdata_first", {32'd0, wrdata}, 64'hDEADBEEF);
        d0 = wrdata;
        a0 = wraddr;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_stable", {15'd0, wrvld, a0, d0}, {15'd0, 1'b1, wraddr, wrdata});
            chk("bp_rdrdy_low", {63'd0, rdrdy}, 64'd0);
        end
        @(posedge clk);
        #1;
        man_rdy = 1'b1;
        @(posedge clk);
        #1;
        man_rdy = 1'b0;
        @(negedge clk);
        chk("rdrdy_after_resp", {63'd0, rdrdy}, 64'd1);
        chk("wrvld_after_resp", {63'd0, wrvld}, 64'd0);
        @(posedge clk);
        #1;
        rdy_manual = 1'b0;

        // Out-of-window requests, then saturation
        do_req(16'h1FFF, 32'h11111111, w);
        do_req(16'h2080, 32'h22222222, w);
        rdvld = 1'b0;
        @(negedge clk);
        chk("errcnt_two", {56'd0, errcnt}, 64'(exp_err));
        chk("errcnt_two_abs", {56'd0, errcnt}, 64'd2);
        @(posedge clk);
        #1;
        do_req(16'h2045, 32'h0000ABCD, w);
        for (int i = 0; i < 298; i++) begin
            do_req(16'h2000 + 16'($urandom_range(128, 65535)), $urandom, w);
        end
        rdvld = 1'b0;
        @(negedge clk);
        chk("errcnt_saturated", {56'd0, errcnt}, 64'd255);
        @(posedge clk);
        #1;

        // Streaming: 64 back-to-back writes must never stall
        for (int i = 0; i < 64; i++) begin
            do_req(16'h2000 + 16'(i), 32'(i), w);
            chk("stream_no_stall", 64'(w), 64'd0);
        end
        for (int i = 0; i < 64; i++) begin
            do_req(16'h2040 + 16'(i), 32'($urandom_range(0, 65535)), w);
        end
        idle_cycle();

        // Random mix of writes, reads and drops with random response backpressure
        for (int i = 0; i < 200; i++) begin
            int k;
            k = $urandom_range(0, 9);
            if (k < 4) begin
                do_req(16'h2000 + 16'($urandom_range(0, 63)), $urandom, w);
            end else if (k < 8) begin
                do_req(16'h2040 + 16'($urandom_range(0, 63)), $urandom, w);
            end else begin
                do_req(16'h2000 + 16'($urandom_range(128, 65535)), $urandom, w);
            end
            if ($urandom_range(0, 4) == 0) idle_cycle();
        end
        idle_cycle();
        @(negedge clk);
        chk("errcnt_after_mix", {56'd0, errcnt}, 64'(exp_err));
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        #1;

        // Reset in the middle of a pending response
        rdy_manual = 1'b1;
        man_rdy    = 1'b0;
        mid_val    = $urandom;
        do_req(16'h200A, mid_val, w);
        do_req(16'h204A, 32'h00005A5A, w);
        rdvld = 1'b0;
        for (int i = 0; i < 10 && !wrvld; i++) @(negedge clk);
        chk("mid_wrvld_up", {63'd0, wrvld}, 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_err = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_wrvld_dropped", {63'd0, wrvld}, 64'd0);
        chk("mid_errcnt_cleared", {56'd0, errcnt}, 64'd0);
        chk("mid_rdrdy_back", {63'd0, rdrdy}, 64'd1);
        @(posedge clk);
        #1;
        rdy_manual = 1'b0;
        do_req(16'h204A, 32'h0000C0DE, w);
        idle_cycle();

        // Drain outstanding responses
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/powlib_busresp.md
POWLIB_BUSRESP -- requirements
Module: powlib_busresp

Interface
REQ-001 Parameter B_AW, 16: bus address width.
REQ-002 Parameter B_DW, 32: bus data width, B_DW >= B_AW.
REQ-003 Parameter B_BASE, 16'h2000: window base address.
REQ-004 Parameter MAW, 6: memory address width; depth 2^MAW words of B_DW bits.
REQ-005 Parameter ID, "BUSRESP": instance identifier string, used for simulation messages only.
REQ-006 One clock; reset is synchronous and active-low.
REQ-007 clk  input  1  sole clock; all state changes on rising edge.
REQ-008 rst  input  1  synchronous reset, active-low.
REQ-009 rddata  input  B_DW  request data from crossbar read port.
REQ-010 rdaddr  input  B_AW  request address.
REQ-011 rdvld  input  1  request valid.
REQ-012 rdrdy  output  1  request ready.
REQ-013 wrdata  output  B_DW  response data toward crossbar write port.
REQ-014 wraddr  output  B_AW  response (return) address.
REQ-015 wrvld  output  1  response valid.
REQ-016 wrrdy  input  1  response ready.
REQ-017 errcnt  output  8  saturating count of out-of-window requests.

Function
REQ-018 Transfer on either port SHALL occur only on a rising edge where vld and rdy are both 1.
REQ-019 The offset SHALL be computed as rdaddr - B_BASE, modulo 2^B_AW, unsigned.
REQ-020 Offset < 2^MAW: write request; mem[offset] <= rddata on the accepting edge.
REQ-021 2^MAW <= offset < 2^(MAW+1): read request for word (offset - 2^MAW); the return address is rddata[B_AW-1:0].
REQ-022 Any other offset: request accepted and dropped, memory unchanged, errcnt += 1, saturating at 255.
REQ-023 The FSM SHALL have exactly three states: IDLE, RD, RESP.
REQ-024 IDLE: rdrdy = rst; write or drop accepted stays in IDLE; read accepted -> RD, latching word index and return address.
REQ-025 RD: rdrdy=0; memory word registered into wrdata, return address into wraddr, wrvld <= 1; -> RESP unconditionally.
REQ-026 RESP: rdrdy=0; wrvld, wrdata and wraddr SHALL remain stable until wrrdy=1; on that edge wrvld <= 0 -> IDLE.
REQ-027 Read latency: read accepted at edge N; wrvld=1 from edge N+1 onward; rdrdy=1 again the cycle after the response handshake.
REQ-028 Write throughput SHALL be one write per cycle back-to-back while in IDLE.
REQ-029 A read following a write to the same word in the immediately next cycle SHALL return the newly written data.
REQ-030 The block SHALL never assert rdrdy and wrvld in the same cycle.

Reset
REQ-031 While rst=0: state <= IDLE, wrvld <= 0, wrdata <= 0, wraddr <= 0, errcnt <= 0; rdrdy=0 combinationally; no request is accepted.
REQ-032 Memory contents SHALL NOT be cleared by reset and are undefined until written.
REQ-033 Reset asserted in RD or RESP SHALL abandon the pending response with no handshake; wrvld=0 after that edge.

Verification (B_BASE=0x2000, MAW=6)
REQ-034 Reset: hold rst=0 for 2 cycles -> wrvld=0, rdrdy=0, errcnt=0; rdrdy=1 in the first cycle with rst=1.
REQ-035 Write then read: write 0x2005/0xDEADBEEF, then read 0x2045 with data 0x00001234 -> wrvld=1 one edge after acceptance, wraddr=0x1234, wrdata=0xDEADBEEF.
REQ-036 Backpressure: wrrdy=0 for 5 cycles during RESP -> wrvld, wraddr and wrdata are constant and rdrdy=0; after wrrdy=1, rdrdy=1 in the next cycle.
REQ-037 Out-of-window: addresses 0x1FFF and 0x2080 -> both accepted, memory unchanged, errcnt=2; 300 such requests -> errcnt=255.
REQ-038 Streaming: 64 back-to-back writes 0x2000..0x203F with data=i, then 64 reads -> each response returns i with no dropped cycles on the write stream.
REQ-039 Mid-operation reset: rst=0 during RESP -> wrvld=0 after that edge; a subsequent read of the same word returns the previously written data.
